// File: rtl/me_pkg.sv
// Shared definitions for the modular-exponentiation job scheduler.
// State encoding, sticky error bit positions and engine tag width.
package me_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_GAP1,
        S_ME,
        S_GAP2,
        S_OMM,
        S_RESP
    } state_t;

    localparam int ERR_TO    = 0;
    localparam int ERR_SPUR  = 1;
    localparam int ENG_NUM_W = 4;

endpackage

// File: rtl/me_job_sched_if.sv
// Requester handshake and engine control bundle of the me job scheduler.
// master = scheduler side, slave = requesters plus engine side.
interface me_job_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_grant;
    logic                          resp_valid;
    logic [ID_W-1:0]               resp_id;
    logic                          resp_err;
    logic                          resp_ready;
    logic                          busy;
    logic                          en_pre_me_top;
    logic                          en_me_top;
    logic                          en_one_mm_top;
    logic [me_pkg::ENG_NUM_W-1:0]  eng_num;
    logic [me_pkg::ENG_NUM_W-1:0]  eng_num_out;
    logic                          eng_done_top;
    logic [1:0]                    err_sticky;

    modport master (
        input  req_valid, resp_ready, eng_num_out, eng_done_top,
        output req_grant, resp_valid, resp_id, resp_err, busy,
        output en_pre_me_top, en_me_top, en_one_mm_top,
        output eng_num, err_sticky
    );

    modport slave (
        output req_valid, resp_ready, eng_num_out, eng_done_top,
        input  req_grant, resp_valid, resp_id, resp_err, busy,
        input  en_pre_me_top, en_me_top, en_one_mm_top,
        input  eng_num, err_sticky
    );

endinterface

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter; the pointer moves past the winner
// only when the caller takes the grant (i_adv).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adv,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;

    always_comb begin : p_pick
        int j;
        j     = 0;
        w_idx = '0;
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            w_idx = ID_W'(j);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_id         = w_idx;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && o_any) begin
            r_ptr <= (o_id == ID_W'(N_REQ - 1)) ? '0 : o_id + 1'b1;
        end
    end

endmodule

// File: rtl/me_job_sched.sv
// Shares one modular-exponentiation engine among N_REQ requesters and
// sequences pre-compute, exponentiation and Montgomery-out per job.
module me_job_sched
    import me_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = 4,
    parameter int TO_W    = 24
) (
    input logic          clk,
    input logic          rst_n,
    me_job_sched_if.master bus
);

    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    state_t                 r_state;
    logic [N_REQ-1:0]       r_grant;
    logic [ID_W-1:0]        r_id;
    logic [ENG_NUM_W-1:0]   r_eng_num;
    logic                   r_en_pre;
    logic                   r_en_me;
    logic                   r_en_omm;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic [1:0]             r_err;
    logic                   r_done_q;
    logic [TO_W-1:0]        r_to_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;

    logic [N_REQ-1:0]       w_gnt;
    logic [ID_W-1:0]        w_gnt_id;
    logic                   w_any;
    logic                   w_done_ev;
    logic [TO_W-1:0]        w_to_nxt;
    logic                   w_to_hit;

    // Engine done is a toggle; any level change is one completed phase.
    assign w_done_ev = bus.eng_done_top ^ r_done_q;
    assign w_to_nxt  = r_to_cnt + 1'b1;
    assign w_to_hit  = &w_to_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.req_valid),
        .i_adv (r_state == S_IDLE),
        .o_gnt (w_gnt),
        .o_id  (w_gnt_id),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_id         <= '0;
            r_eng_num    <= '0;
            r_en_pre     <= 1'b0;
            r_en_me      <= 1'b0;
            r_en_omm     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_err        <= '0;
            r_done_q     <= 1'b0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_done_q <= bus.eng_done_top;
            r_grant  <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_done_ev) r_err[ERR_SPUR] <= 1'b1;
                    if (w_any) begin
                        r_grant   <= w_gnt;
                        r_id      <= w_gnt_id;
                        r_eng_num <= ENG_NUM_W'(w_gnt_id);
                        r_en_pre  <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= S_PRE;
                    end
                end
                S_PRE, S_ME: begin
                    if (w_done_ev) begin
                        r_en_pre  <= 1'b0;
                        r_en_me   <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= (r_state == S_PRE) ? S_GAP1 : S_GAP2;
                    end else if (w_to_hit) begin
                        r_en_pre      <= 1'b0;
                        r_en_me       <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_resp_err    <= 1'b1;
                        r_err[ERR_TO] <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_to_cnt <= w_to_nxt;
                    end
                end
                S_GAP1, S_GAP2: begin
                    if (w_done_ev) r_err[ERR_SPUR] <= 1'b1;
                    if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        r_to_cnt <= '0;
                        if (r_state == S_GAP1) begin
                            r_en_me <= 1'b1;
                            r_state <= S_ME;
                        end else begin
                            r_en_omm <= 1'b1;
                            r_state  <= S_OMM;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_OMM: begin
                    if (w_done_ev) begin
                        r_en_omm     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                        if (bus.eng_num_out != r_eng_num) begin
                            r_resp_err      <= 1'b1;
                            r_err[ERR_SPUR] <= 1'b1;
                        end
                    end else if (w_to_hit) begin
                        r_en_omm      <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_resp_err    <= 1'b1;
                        r_err[ERR_TO] <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_to_cnt <= w_to_nxt;
                    end
                end
                S_RESP: begin
                    if (w_done_ev) r_err[ERR_SPUR] <= 1'b1;
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_grant     = r_grant;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_id       = r_id;
    assign bus.resp_err      = r_resp_err;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.en_pre_me_top = r_en_pre;
    assign bus.en_me_top     = r_en_me;
    assign bus.en_one_mm_top = r_en_omm;
    assign bus.eng_num       = r_eng_num;
    assign bus.err_sticky    = r_err;

endmodule

// File: doc/me_job_sched.md
Name: me_job_sched

Overview:
- Round-robin scheduler that shares one modular-exponentiation engine (me wrapper) among N_REQ requesters.
- Per granted job, sequences the three engine phases in order: pre-computation (en_pre_me_top), exponentiation (en_me_top), conversion out of Montgomery form (en_one_mm_top).
- Detects phase completion from the engine's toggle-style done_top, checks the returned num_out tag, and reports completion or error to the requester.
- Operand buses (a/e/m/m_n/m_prime) are not routed here; an external mux selects them with eng_num.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester index width; ceil(log2(N_REQ)), at most 4.
- GAP_CYC, 4, low cycles between phase enables; must be >= 3 so the engine's rising-edge detector re-arms.
- TO_W, 24, phase timeout counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester job request (level, held until granted).
- req_grant  out  N_REQ  one-hot, one-cycle pulse acknowledging the accepted request.
- resp_valid  out  1  job finished; held until resp_ready.
- resp_id  out  ID_W  requester index of the finished job.
- resp_err  out  1  job ended by timeout or tag mismatch.
- resp_ready  in  1  response accepted.
- busy  out  1  any state other than IDLE.
- en_pre_me_top  out  1  level enable to the engine.
- en_me_top  out  1  level enable to the engine.
- en_one_mm_top  out  1  level enable to the engine.
- eng_num  out  4  job tag to the engine: zero-extended granted id; also the operand-mux select.
- eng_num_out  in  4  tag returned by the engine.
- eng_done_top  in  1  engine done; toggles once per completed phase.
- err_sticky  out  2  bit0 timeout, bit1 spurious done or tag mismatch; cleared only by reset.

Behaviour:
Reset (async, rst_n low):
- All outputs 0; state IDLE; round-robin pointer 0.
- done_q = 0, matching the engine's done toggle reset value.
- Reset mid-job abandons the job; no response is issued.

Done detection:
- done_q registers eng_done_top every cycle.
- done_ev = eng_done_top XOR done_q (one-cycle event).

States:
- IDLE, PRE, GAP1, ME, GAP2, OMM, RESP.
- One engine enable is high only in its own phase state (PRE / ME / OMM); all three are low elsewhere.

IDLE:
- If any req_valid is set, grant the first set bit at or after the pointer, wrapping around.
- Grant cycle: req_grant pulses 1 cycle; job id and eng_num are registered; pointer <= id+1 (mod N_REQ); next state PRE.
- With no valid requests, remain in IDLE.

PRE / ME / OMM (phase states):
- The matching enable goes high on state entry and is held until done_ev.
- Timeout counter clears on phase entry and increments each cycle.
- On done_ev: drop the enable and go PRE->GAP1, ME->GAP2, OMM->RESP.
- On done_ev in OMM, also compare eng_num_out with eng_num; a mismatch sets resp_err and err_sticky[1].
- If the counter reaches all-ones before done_ev: drop the enable, set resp_err and err_sticky[0], go to RESP (remaining phases skipped).

GAP1 / GAP2:
- All enables low for exactly GAP_CYC cycles, counted by a gap counter; then go to ME / OMM.
- A done_ev during a gap sets err_sticky[1] and does not change state.

RESP:
- resp_valid = 1 with resp_id = job id and resp_err.
- On resp_ready: clear resp_valid and resp_err, go to IDLE.
- Minimum of one IDLE cycle between jobs, so no grant occurs in the same cycle as resp_ready.

Other boundary rules:
- A done_ev in IDLE or RESP sets err_sticky[1] and is otherwise ignored.
- Requests arriving while busy wait; req_valid must be held until granted.
- A requester that deasserts before grant is simply not granted.
- Latency, request to grant: 1 cycle from the first IDLE cycle with req_valid.
- eng_num is stable for the whole job, from the grant cycle to resp acceptance.

Decomposition:
- Shared package me_pkg: state encoding enum (IDLE..RESP), err_sticky bit indices, and the eng_num width (4) as a constant.
- One natural sub-module: rr_arbiter (N_REQ-wide, pointer-based, with grant and advance inputs), reusable by other shared engines.
- Phase sequencing, counters and done detection stay in me_job_sched.

Test Plan:
- Single job: req_valid=4'b0010; engine model toggles done 50 cycles after each enable rise and echoes the tag. Expect: grant=4'b0010; eng_num=1; enables rise in order PRE, ME, OMM with exactly 4 low cycles between them; then resp_valid, resp_id=1, resp_err=0.
- Fairness: req_valid=4'b1111 held; expect grant order 0,1,2,3,0; then req_valid=4'b1001 with pointer at 1 -> next grant is 3.
- Timeout: TO_W=8, engine never toggles done; expect en_pre_me_top low after 255 cycles, resp_err=1, err_sticky=2'b01, ME and OMM never enabled.
- Tag mismatch: engine returns eng_num_out=4'h7 for job id 2; expect resp_err=1 and err_sticky[1]=1 at RESP.
- Spurious done: toggle eng_done_top while in GAP1; expect err_sticky[1]=1 and the ME enable still rises exactly at GAP_CYC.
- Reset mid-ME: assert rst_n low; expect all enables, resp_valid and busy at 0 asynchronously; after release, a new request is granted from pointer 0.
